// File: rtl/banco_pkg.sv
// Shared defaults, clear-FSM state type and zero helper for the banco_regs register bank.
package banco_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int ZERO_W_MAX = 64;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

    // Wide zero; callers size it down with a width cast.
    function automatic logic [ZERO_W_MAX-1:0] zero_word();
        return '0;
    endfunction

endpackage

// File: rtl/banco_clear_fsm.sv
// Clear-sweep sequencer: walks idx over every register once, holding busy for DEPTH cycles.
module banco_clear_fsm
    import banco_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear_req,
    output logic              o_busy,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_idx,   w_idx_nxt;
    logic              r_busy,  w_busy_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLR_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        case (r_state)
            CLR_IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = CLR_SWEEP;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            CLR_SWEEP: begin
                // clear_req is deliberately ignored here: no re-arm mid-sweep.
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = CLR_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = CLR_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign o_busy    = r_busy;
    assign o_clr_en  = (r_state == CLR_SWEEP);
    assign o_clr_idx = r_idx;

endmodule

// File: rtl/banco_regs.sv
// Parametrised register bank: 2 operand reads, store read, 1 write, debug read, clear sweep.
// Optional same-edge write-to-read forwarding is enabled by defining BANCO_BYPASS_EN.
module banco_regs
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [DATA_W-1:0] data_c,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] store,
    input  logic              clear_req,
    output logic              busy,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [DATA_W-1:0]            r_data_a, r_data_b, r_store;
    logic [DATA_W-1:0]            r_dbg_stage, r_dbg_data;
    logic [1:0]                   r_dbg_vld_pipe;

    logic              w_busy, w_clr_en, w_wr_ok;
    logic [ADDR_W-1:0] w_clr_idx;

    banco_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
        .clock       (clock),
        .reset       (reset),
        .i_clear_req (clear_req),
        .o_busy      (w_busy),
        .o_clr_en    (w_clr_en),
        .o_clr_idx   (w_clr_idx)
    );

    assign w_wr_ok = write_en && !w_busy && !((ZERO_REG != 0) && (addr_c == '0));

    // Read view of the array at this edge; forwarding only sees writes that actually land.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        if ((ZERO_REG != 0) && (a == '0))
            return DATA_W'(zero_word());
`ifdef BANCO_BYPASS_EN
        if (w_wr_ok && (a == addr_c))
            return data_c;
`endif
        return r_mem[a];
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            r_mem <= '0;
        else if (w_clr_en)
            r_mem[w_clr_idx] <= DATA_W'(zero_word());
        else if (w_wr_ok)
            r_mem[addr_c] <= data_c;
    end

    // Debug: contents sampled at the request edge, presented one edge later.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_a       <= '0;
            r_data_b       <= '0;
            r_store        <= '0;
            r_dbg_stage    <= '0;
            r_dbg_data     <= '0;
            r_dbg_vld_pipe <= '0;
        end else begin
            r_data_a       <= rd(addr_a);
            r_data_b       <= rd(addr_b);
            r_store        <= rd(addr_c);
            r_dbg_vld_pipe <= {r_dbg_vld_pipe[0], dbg_req};
            if (dbg_req)
                r_dbg_stage <= rd(dbg_addr);
            if (r_dbg_vld_pipe[0])
                r_dbg_data <= r_dbg_stage;
        end
    end

    assign data_a    = r_data_a;
    assign data_b    = r_data_b;
    assign store     = r_store;
    assign busy      = w_busy;
    assign dbg_valid = r_dbg_vld_pipe[1];
    assign dbg_data  = r_dbg_data;

endmodule

// File: tb/tb_banco_regs.sv
// Directed bench for banco_regs: default bank plus a ZERO_REG=1 instance on shared inputs.
module tb_banco_regs;

`ifdef BANCO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, write_en, clear_req, dbg_req;
    logic [3:0]  addr_a, addr_b, addr_c, dbg_addr;
    logic [15:0] data_c;

    logic [15:0] data_a, data_b, store, dbg_data;
    logic        busy, dbg_valid;
    logic [15:0] z_data_a, z_data_b, z_store, z_dbg_data;
    logic        z_busy, z_dbg_valid;

    int nvec  = 0;
    int nfail = 0;
    int cnt;

    always #5 clock = ~clock;

    banco_regs #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u_dut (
        .clock(clock), .reset(reset), .write_en(write_en),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .data_c(data_c),
        .data_a(data_a), .data_b(data_b), .store(store),
        .clear_req(clear_req), .busy(busy),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_valid(dbg_valid), .dbg_data(dbg_data)
    );

    banco_regs #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_dz (
        .clock(clock), .reset(reset), .write_en(write_en),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .data_c(data_c),
        .data_a(z_data_a), .data_b(z_data_b), .store(z_store),
        .clear_req(clear_req), .busy(z_busy),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_valid(z_dbg_valid), .dbg_data(z_dbg_data)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0; clear_req = 1'b0; dbg_req = 1'b0;
        addr_a = '0; addr_b = '0; addr_c = '0; dbg_addr = '0; data_c = '0;
        step(); step();
        chk("rst_data_a", data_a, 0);
        chk("rst_data_b", data_b, 0);
        chk("rst_store", store, 0);
        chk("rst_dbg_data", dbg_data, 0);
        chk("rst_dbg_valid", dbg_valid, 0);
        chk("rst_busy", busy, 0);

        // Basic write then read
        reset = 1'b0;
        write_en = 1'b1; addr_c = 4'd3; data_c = 16'hBEEF;
        step();
        write_en = 1'b0; addr_a = 4'd3; addr_c = 4'd7;
        step();
        chk("wr_rd_a", data_a, 16'hBEEF);
        chk("wr_rd_b_other", data_b, 0);
        chk("wr_rd_store_other", store, 0);

        // Same-edge write and read
        write_en = 1'b1; addr_c = 4'd5; data_c = 16'h1234; addr_b = 4'd5;
        step();
        chk("same_edge_b", data_b, BYP ? 16'h1234 : 16'h0000);
        chk("same_edge_store", store, BYP ? 16'h1234 : 16'h0000);
        write_en = 1'b0;
        step();
        chk("next_edge_b", data_b, 16'h1234);

        // Back-to-back debug reads
        write_en = 1'b1;
        addr_c = 4'd1; data_c = 16'h0011; step();
        addr_c = 4'd2; data_c = 16'h0022; step();
        addr_c = 4'd3; data_c = 16'h0033; step();
        write_en = 1'b0;
        dbg_req = 1'b1; dbg_addr = 4'd1; step();
        chk("dbg_lat_valid", dbg_valid, 0);
        dbg_addr = 4'd2; step();
        chk("dbg1_valid", dbg_valid, 1);
        chk("dbg1_data", dbg_data, 16'h0011);
        dbg_addr = 4'd3; step();
        chk("dbg2_valid", dbg_valid, 1);
        chk("dbg2_data", dbg_data, 16'h0022);
        dbg_req = 1'b0; step();
        chk("dbg3_valid", dbg_valid, 1);
        chk("dbg3_data", dbg_data, 16'h0033);
        step();
        chk("dbg_end_valid", dbg_valid, 0);
        chk("dbg_hold_data", dbg_data, 16'h0033);

        // Fill, sweep, dropped write during sweep, pre-clear reads
        write_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr_c = 4'(i); data_c = 16'hA000 + 16'(i);
            step();
        end
        write_en = 1'b0; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("sweep_busy_start", busy, 1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            write_en = (cnt == 3); addr_c = 4'd9; data_c = 16'hDEAD;
            addr_a = 4'(cnt);
            step();
            chk("sweep_preclear_rd", data_a, 16'hA000 + 16'(cnt));
            cnt++;
        end
        write_en = 1'b0;
        chk("sweep_busy_cycles", cnt, 16);
        for (int i = 0; i < 16; i++) begin
            addr_a = 4'(i);
            step();
            chk("post_sweep_zero", data_a, 0);
        end

        // Reset in the middle of a sweep
        write_en = 1'b1; addr_c = 4'd12; data_c = 16'h5555;
        step();
        write_en = 1'b0; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (7) step();
        chk("mid_sweep_busy", busy, 1);
        reset = 1'b1; write_en = 1'b1; addr_c = 4'd2; data_c = 16'h7777;
        dbg_req = 1'b1; dbg_addr = 4'd12; addr_a = 4'd12;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_data_a", data_a, 0);
        chk("abort_store", store, 0);
        chk("abort_dbg_valid", dbg_valid, 0);
        chk("abort_dbg_data", dbg_data, 0);
        reset = 1'b0; write_en = 1'b0; dbg_req = 1'b0;
        addr_a = 4'd12; addr_b = 4'd2;
        step();
        chk("abort_reg12_zero", data_a, 0);
        chk("abort_write_dropped", data_b, 0);
        repeat (3) step();
        chk("abort_idle", busy, 0);

        // Hardwired zero register
        write_en = 1'b1; addr_c = 4'd0; data_c = 16'hFFFF;
        step();
        write_en = 1'b0; addr_a = 4'd0; addr_b = 4'd0; addr_c = 4'd0;
        dbg_req = 1'b1; dbg_addr = 4'd0;
        step();
        dbg_req = 1'b0;
        step();
        chk("zr_data_a", z_data_a, 0);
        chk("zr_data_b", z_data_b, 0);
        chk("zr_store", z_store, 0);
        chk("zr_dbg_valid", z_dbg_valid, 1);
        chk("zr_dbg_data", z_dbg_data, 0);
        chk("zr_busy", z_busy, 0);
        chk("nozr_data_a", data_a, 16'hFFFF);
        chk("nozr_dbg_data", dbg_data, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/banco_regs.md
# banco_regs

Parametrised general-purpose register bank for the 16-bit MIPS datapath; successor to the fixed 16×16 bank. Provides two operand read ports, a store-data read port, one write port, and a handshaked debug/display read port. Adds an optional hardwired zero register and a multi-cycle clear sweep with a busy flag. The CPU control FSM gates `write_en` by state before it reaches this block; the bank itself is state-agnostic.

## Interface
- `DATA_W`, 16, register width in bits
- `ADDR_W`, 4, address width; depth `DEPTH = 2**ADDR_W`
- `ZERO_REG`, 0, when 1 register 0 reads as zero and ignores writes
- `clock`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `write_en`  in  1  write `data_c` to `addr_c` this edge
- `addr_a`, `addr_b`, `addr_c`  in  ADDR_W  operand A, operand B, and destination/store addresses
- `data_c`  in  DATA_W  write data
- `data_a`, `data_b`  out  DATA_W  registered read of `addr_a` / `addr_b`
- `store`  out  DATA_W  registered read of `addr_c`, used as store data
- `clear_req`  in  1  start clear sweep (level sampled in IDLE)
- `busy`  out  1  clear sweep in progress
- `dbg_req`  in  1  debug read request
- `dbg_addr`  in  ADDR_W  debug read address
- `dbg_valid`  out  1  one-cycle pulse, `dbg_data` valid
- `dbg_data`  out  DATA_W  debug read data; holds last value until next valid

## Operation
- Storage is `DEPTH` × `DATA_W` flops.
- Write: on an edge with `write_en=1` and `busy=0`, set `reg[addr_c] <= data_c`. A write with `busy=1` is dropped. With `ZERO_REG=1`, a write to address 0 is dropped.
- Reads: each edge samples `reg[addr_a]`, `reg[addr_b]`, `reg[addr_c]` into `data_a`, `data_b`, `store`. With `ZERO_REG=1`, address 0 yields 0.
- Clear FSM states:
  - IDLE: `clear_req=1` moves to CLEAR with `idx<=0` and `busy<=1`.
  - CLEAR: each edge sets `reg[idx]<=0` and `idx<=idx+1`. On the edge that clears `idx=DEPTH-1`, go to IDLE and set `busy<=0`.
  - `clear_req` in CLEAR is ignored; there is no re-arm.
- Debug: `dbg_req=1` at edge N gives `dbg_valid=1` and `dbg_data=reg[dbg_addr]` after edge N+1 (sampled at N). Back-to-back requests give back-to-back pulses. Requests are served during CLEAR and return current contents.
- Simultaneous events:
  - `write_en` with `clear_req` in IDLE: the write completes, then the sweep starts and later clears that register.
  - Read of the address being cleared in CLEAR returns the pre-clear value.

## Timing
- Read latency is 1 cycle: address valid before edge N, data valid after edge N.
- Write is visible to a read address presented on the following cycle. Same-cycle behaviour is set by the macro (see Configuration).
- Clear sweep: `busy` is high for exactly `DEPTH` cycles, starting the cycle after `clear_req` is sampled.
- Reset:
  - All registers 0, `data_a`/`data_b`/`store`/`dbg_data` = 0, `dbg_valid`=0, `busy`=0, FSM IDLE, `idx`=0.
  - Reset mid-sweep aborts the sweep and returns the block to IDLE with everything zeroed.
  - Reset overrides any same-cycle write or request.

## Configuration
- `BANCO_BYPASS_EN` defined: a write and a read to the same address on the same edge return the new `data_c` on that port, for `data_a`, `data_b`, `store` and `dbg_data`. Bypass is suppressed when the write is dropped (busy, or zero register).
- Undefined: the same-edge read returns the old contents, and the new value is seen one cycle later.

## Structure
- Package `banco_pkg`: default `DATA_W`/`ADDR_W`, clear-FSM state enum `clr_state_t` {CLR_IDLE, CLR_SWEEP}, and a zero-constant helper.
- Sub-module `banco_clear_fsm`: owns state, `idx` and `busy`, and outputs the clear strobe and index. Array, read ports and debug port stay in `banco_regs`.

## Test plan
- Reset, write `addr_c=3, data_c=16'hBEEF`, then read `addr_a=3` next cycle -> `data_a=16'hBEEF` one edge later. Other ports read 0.
- Same-edge write `5<=16'h1234` and `addr_b=5` -> `data_b=16'h1234` with `BANCO_BYPASS_EN`, and the old value 0 without it.
- Fill all 16 registers, pulse `clear_req` -> `busy` high for 16 cycles. `write_en` during the sweep is dropped, and afterwards every register reads 0.
- Assert `reset` at sweep cycle 7 -> `busy`=0 next edge, all outputs 0, FSM IDLE.
- `ZERO_REG=1`: write `0<=16'hFFFF`, then read address 0 on all ports -> 0.
- `dbg_req` on 3 consecutive cycles for addresses 1, 2, 3 (holding 16'h0011, 16'h0022, 16'h0033) -> 3 consecutive `dbg_valid` pulses with matching `dbg_data`, each one cycle after its request.
